// File: rtl/regfile_write_queue_if.sv
// Write-request channel between the execute/writeback
// producer and the register-file write queue.
interface regfile_write_queue_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_address;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (
    output wr_valid,
    output wr_address,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_address,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/regfile_write_queue.sv
// Circular write queue in front of the 8x8 FileRegister,
// with flush, stall and a newest-entry bypass lookup.
module regfile_write_queue #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  regfile_write_queue_if.slave  wr,
  input  logic                  drain_en,
  input  logic                  flush,
  output logic                  rf_load,
  output logic [ADDR_WIDTH-1:0] rf_address,
  output logic [DATA_WIDTH-1:0] rf_d_in,
  input  logic [ADDR_WIDTH-1:0] lookup_address,
  output logic                  lookup_hit,
  output logic [DATA_WIDTH-1:0] lookup_data,
  output logic [CW-1:0]         count,
  output logic                  empty
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          push;
  logic          pop;
  entry_t        head_e;

  assign count      = count_q;
  assign empty      = (count_q == '0);
  assign wr.wr_ready = (count_q != CW'(DEPTH)) && !flush;
  assign push       = wr.wr_valid && wr.wr_ready;
  assign pop        = rf_load;
  assign head_e     = mem_q[head_q];

  always_comb begin
    rf_load    = !empty && drain_en && !flush;
    rf_address = '0;
    rf_d_in    = '0;
    if (!empty) begin
      rf_address = head_e.addr;
      rf_d_in    = head_e.data;
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop)  head_d = head_q + PW'(1);
      if (push) tail_d = tail_q + PW'(1);
      if (push && !pop) count_d = count_q + CW'(1);
      if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  // Later (newer) matches overwrite earlier ones.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q &&
          mem_q[head_q + PW'(i)].addr == lookup_address) begin
        lookup_hit  = 1'b1;
        lookup_data = mem_q[head_q + PW'(i)].data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail_q] <= entry_t'{
        addr: wr.wr_address,
        data: wr.wr_data
      };
    end
  end

endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed bench for regfile_write_queue with a
// behavioural FileRegister fed from the rf_* port.
module tb_regfile_write_queue;

  logic       clk;
  logic       reset;
  logic       drain_en;
  logic       flush;
  logic       rf_load;
  logic [2:0] rf_address;
  logic [7:0] rf_d_in;
  logic [2:0] lookup_address;
  logic       lookup_hit;
  logic [7:0] lookup_data;
  logic [2:0] count;
  logic       empty;
  logic [7:0] rf_model [8];
  int         checks;
  int         errors;

  regfile_write_queue_if #(
    .ADDR_WIDTH(3),
    .DATA_WIDTH(8)
  ) wif ();

  regfile_write_queue #(
    .DEPTH(4),
    .ADDR_WIDTH(3),
    .DATA_WIDTH(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wr(wif.slave),
    .drain_en(drain_en),
    .flush(flush),
    .rf_load(rf_load),
    .rf_address(rf_address),
    .rf_d_in(rf_d_in),
    .lookup_address(lookup_address),
    .lookup_hit(lookup_hit),
    .lookup_data(lookup_data),
    .count(count),
    .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rf_load) rf_model[rf_address] <= rf_d_in;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic offer(input logic v,
                       input logic [2:0] a,
                       input logic [7:0] d);
    wif.wr_valid   = v;
    wif.wr_address = a;
    wif.wr_data    = d;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 8; i++) rf_model[i] = 8'h00;
    reset          = 1'b0;
    drain_en       = 1'b0;
    flush          = 1'b0;
    lookup_address = 3'd0;
    offer(1'b0, 3'd0, 8'h00);
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_ready", 32'(wif.wr_ready), 1);
    chk("rst_load", 32'(rf_load), 0);
    chk("rst_addr", 32'(rf_address), 0);
    chk("rst_din", 32'(rf_d_in), 0);
    chk("rst_hit", 32'(lookup_hit), 0);
    chk("rst_ldata", 32'(lookup_data), 0);
    tick;
    reset = 1'b1;

    // single write, one-cycle latency
    offer(1'b1, 3'd3, 8'hAA);
    drain_en       = 1'b1;
    lookup_address = 3'd3;
    #1;
    chk("s_load0", 32'(rf_load), 0);
    chk("s_nobyp", 32'(lookup_hit), 0);
    tick;
    offer(1'b0, 3'd0, 8'h00);
    #1;
    chk("s_load", 32'(rf_load), 1);
    chk("s_addr", 32'(rf_address), 3);
    chk("s_din", 32'(rf_d_in), 8'hAA);
    chk("s_hit", 32'(lookup_hit), 1);
    chk("s_ldata", 32'(lookup_data), 8'hAA);
    tick;
    #1;
    chk("s_empty", 32'(empty), 1);
    chk("s_rf3", 32'(rf_model[3]), 8'hAA);

    // fill to full, overflow ignored, ordered drain
    drain_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      offer(1'b1, 3'(i), 8'(8'h10 + i));
      tick;
    end
    offer(1'b0, 3'd0, 8'h00);
    #1;
    chk("f_count", 32'(count), 4);
    chk("f_ready", 32'(wif.wr_ready), 0);
    chk("f_hold_ld", 32'(rf_load), 0);
    chk("f_hold_d", 32'(rf_d_in), 8'h10);
    offer(1'b1, 3'd7, 8'h77);
    tick;
    offer(1'b0, 3'd0, 8'h00);
    #1;
    chk("f_count5", 32'(count), 4);
    drain_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("f_dload", 32'(rf_load), 1);
      chk("f_daddr", 32'(rf_address), i);
      chk("f_ddin", 32'(rf_d_in), 8'h10 + i);
      tick;
    end
    #1;
    chk("f_empty", 32'(empty), 1);
    chk("f_rf2", 32'(rf_model[2]), 8'h12);
    chk("f_rf7", 32'(rf_model[7]), 8'h00);

    // bypass: newest entry wins
    drain_en = 1'b0;
    offer(1'b1, 3'd5, 8'h01);
    tick;
    offer(1'b1, 3'd5, 8'h02);
    tick;
    offer(1'b0, 3'd0, 8'h00);
    lookup_address = 3'd5;
    #1;
    chk("b_hit5", 32'(lookup_hit), 1);
    chk("b_data5", 32'(lookup_data), 8'h02);
    lookup_address = 3'd6;
    #1;
    chk("b_hit6", 32'(lookup_hit), 0);
    chk("b_data6", 32'(lookup_data), 0);
    drain_en       = 1'b1;
    lookup_address = 3'd5;
    #1;
    chk("b_drhit", 32'(lookup_hit), 1);
    chk("b_drdata", 32'(lookup_data), 8'h02);
    tick;
    tick;
    #1;
    chk("b_empty", 32'(empty), 1);
    chk("b_rf5", 32'(rf_model[5]), 8'h02);

    // streaming through pointer wrap
    for (int i = 0; i < 10; i++) begin
      offer(1'b1, 3'(i), 8'(8'h20 + i));
      #1;
      chk("st_ready", 32'(wif.wr_ready), 1);
      if (i > 0) begin
        chk("st_count", 32'(count), 1);
        chk("st_load", 32'(rf_load), 1);
        chk("st_din", 32'(rf_d_in), 8'h20 + i - 1);
      end
      tick;
    end
    offer(1'b0, 3'd0, 8'h00);
    #1;
    chk("st_last", 32'(rf_d_in), 8'h29);
    chk("st_lastad", 32'(rf_address), 1);
    tick;
    #1;
    chk("st_empty", 32'(empty), 1);
    chk("st_rf6", 32'(rf_model[6]), 8'h26);
    chk("st_rf1", 32'(rf_model[1]), 8'h29);

    // flush with concurrent push
    drain_en = 1'b0;
    offer(1'b1, 3'd4, 8'h44);
    tick;
    offer(1'b1, 3'd2, 8'h42);
    tick;
    offer(1'b1, 3'd7, 8'h47);
    tick;
    #1;
    chk("fl_count3", 32'(count), 3);
    offer(1'b1, 3'd6, 8'h66);
    flush    = 1'b1;
    drain_en = 1'b1;
    #1;
    chk("fl_load", 32'(rf_load), 0);
    chk("fl_ready", 32'(wif.wr_ready), 0);
    tick;
    flush = 1'b0;
    offer(1'b0, 3'd0, 8'h00);
    #1;
    chk("fl_count", 32'(count), 0);
    chk("fl_empty", 32'(empty), 1);
    chk("fl_load2", 32'(rf_load), 0);
    tick;
    chk("fl_rf6", 32'(rf_model[6]), 8'h26);
    chk("fl_rf4", 32'(rf_model[4]), 8'h24);
    chk("fl_rf7", 32'(rf_model[7]), 8'h27);

    // asynchronous reset between edges
    drain_en = 1'b0;
    offer(1'b1, 3'd0, 8'h55);
    tick;
    offer(1'b1, 3'd1, 8'h56);
    tick;
    offer(1'b0, 3'd0, 8'h00);
    drain_en = 1'b1;
    #1;
    chk("ar_count2", 32'(count), 2);
    chk("ar_load1", 32'(rf_load), 1);
    #1;
    reset = 1'b0;
    #1;
    chk("ar_count", 32'(count), 0);
    chk("ar_load", 32'(rf_load), 0);
    chk("ar_empty", 32'(empty), 1);
    #1;
    reset = 1'b1;
    tick;
    #1;
    chk("ar_after", 32'(empty), 1);
    chk("ar_rf0", 32'(rf_model[0]), 8'h28);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_queue.md
# regfile_write_queue

Buffers register-write requests from the execute/writeback logic and drains them, one per clock, into the 8 x 8-bit `FileRegister` through its `load`/`address`/`d_in` port. Writes arriving in bursts are absorbed by a small FIFO, and writebacks can be stalled or flushed. A combinational lookup port exposes the newest pending value for any register, so read logic can bypass writes not yet committed.

## Interface
- `DEPTH`, 4: queue entries; power of two, at least 2.
- `ADDR_WIDTH`, 3: register address width; matches `FileRegister`.
- `DATA_WIDTH`, 8: register data width.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `wr_valid` in 1: producer offers a write this cycle.
- `wr_ready` out 1: queue accepts a write this cycle.
- `wr_address` in ADDR_WIDTH: destination register of the offered write.
- `wr_data` in DATA_WIDTH: data of the offered write.
- `drain_en` in 1: permits draining the head entry to the register file.
- `flush` in 1: discards all queued entries at the next edge.
- `rf_load` out 1: drives `FileRegister.load`.
- `rf_address` out ADDR_WIDTH: drives `FileRegister.address`.
- `rf_d_in` out DATA_WIDTH: drives `FileRegister.d_in`.
- `lookup_address` in ADDR_WIDTH: register being read by bypass logic.
- `lookup_hit` out 1: a pending entry targets `lookup_address`.
- `lookup_data` out DATA_WIDTH: newest pending data for `lookup_address`.
- `count` out clog2(DEPTH)+1: number of occupied entries.
- `empty` out 1: `count == 0`.

## Operation
- Storage is a circular FIFO with head pointer, tail pointer and occupancy counter. Entry payload is {address, data}. The payload array is not reset.
- Push: when `wr_valid && wr_ready`, the entry is written at the tail and the tail advances, modulo DEPTH.
- `wr_ready = (count != DEPTH) && !flush`. A pop in the same cycle does not free space for a push when the queue is full; a full queue holds `wr_ready` low.
- Pop: when `rf_load` is high, the head entry is committed to `FileRegister` at the edge, and the head advances.
- `rf_load = !empty && drain_en && !flush`.
- `rf_address` and `rf_d_in` present the head entry when not empty. They are forced to 0 when empty.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- Flush: at the next edge, pointers and `count` go to 0. Any concurrent push or pop is suppressed, and flush wins over both.
- Lookup (combinational):
  - Scans the occupied entries, head to tail.
  - The newest matching entry wins.
  - The head entry counts as pending even in the cycle it is being drained.
  - A write offered in the same cycle is not visible.
  - On a miss, `lookup_hit = 0` and `lookup_data = 0`.
- Pointer wrap: the pointers are clog2(DEPTH)-bit values that roll over naturally. `count` disambiguates full from empty.

## Timing
- Reset (asynchronous, active-low) values:
  - Pointers and `count` are 0, `empty = 1`, `wr_ready = 1`.
  - `rf_load = 0`, `rf_address = 0`, `rf_d_in = 0`.
  - `lookup_hit = 0`, `lookup_data = 0`.
- Reset asserted mid-burst discards all pending entries immediately, without waiting for a clock edge.
- Latency into an empty queue with `drain_en = 1`:
  - Write accepted at edge N.
  - `rf_load` high during cycle N+1.
  - Register file updated at edge N+1.
- Throughput: one push and one pop per cycle, sustained.
- Hold: with `drain_en = 0`, entries stay queued indefinitely and `rf_*` hold the head entry steady.
- `wr_ready`, `rf_*` and `lookup_*` are combinational from state plus `flush`/`drain_en`/`lookup_address`. None of these outputs depends combinationally on `wr_valid`.

## Test plan
- **Reset then single write:** release `reset`; push {addr 3, data 0xAA} with `drain_en = 1`.
  - The next cycle shows `rf_load = 1`, `rf_address = 3`, `rf_d_in = 0xAA`.
  - The queue is then empty, and `FileRegister` reg 3 reads 0xAA.
- **Fill to full:** with `drain_en = 0`, push addr 0..3 carrying data 0x10..0x13.
  - Result: `count = 4` and `wr_ready = 0`.
  - A fifth push is ignored.
  - Raise `drain_en`: rf writes occur in order 0x10, 0x11, 0x12, 0x13 on consecutive cycles.
- **Bypass:** with `drain_en = 0`, push {5, 0x01} then {5, 0x02}.
  - `lookup_address = 5` gives `hit = 1`, `data = 0x02`.
  - `lookup_address = 6` gives `hit = 0`, `data = 0`.
- **Streaming with wrap-around:** push 10 writes back-to-back with `drain_en = 1`.
  - `count` stays at 1 and `wr_ready` stays 1.
  - All 10 appear on `rf_*` in order, one cycle after acceptance.
- **Flush with concurrent push:** with 3 entries queued, assert `flush` and `wr_valid` together for one cycle.
  - During that cycle, `rf_load = 0` and `wr_ready = 0`.
  - Afterwards, `count = 0`, `empty = 1`, and no register-file write occurs.
- **Asynchronous reset:** with 2 entries queued, pulse `reset` low between edges.
  - `count` drops to 0 and `rf_load` drops to 0 immediately, before the next edge.
